// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions for the host transmitter and the keyboard receiver.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    DATA,
    STOP_W,
    ACK,
    RELEASE
  } ps2_state_t;

  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
  localparam logic [7:0] PS2_ACK_BYTE     = 8'hFA;

  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// PS/2 pad conditioner: 2-flop synchronizer, FILTER_LEN-sample glitch filter
// and a one-cycle pulse on each accepted 1->0 transition.
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic pad,
  output logic level,
  output logic fall
);

  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  // Idle PS/2 lines are pulled high, so reset to 1 to avoid a false edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      level <= 1'b1;
      cnt   <= '0;
      fall  <= 1'b0;
    end else begin
      sync1 <= pad;
      sync2 <= sync1;
      fall  <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync2;
        cnt   <= '0;
        fall  <= ~sync2;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter driving open-drain output-enables.
// Optional PS2_TX_RETRY_EN resends the latched byte up to MAX_RETRY times on failure.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50000000,
  parameter int INHIBIT_US  = 120,
  parameter int TIMEOUT_US  = 2000,
  parameter int FILTER_LEN  = 8
`ifdef PS2_TX_RETRY_EN
  , parameter int MAX_RETRY = 2
`endif
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  input  logic       ps2c_in,
  input  logic       ps2d_in,
  output logic       ps2c_oe,
  output logic       ps2d_oe,
  output logic       tx_done,
  output logic       tx_error,
  output logic       busy
);

  localparam int CYC_PER_US  = CLK_FREQ_HZ / 1000000;
  localparam int INHIBIT_CYC = CYC_PER_US * INHIBIT_US;
  localparam int TIMEOUT_CYC = CYC_PER_US * TIMEOUT_US;
  localparam int TMR_MAX     = (INHIBIT_CYC > TIMEOUT_CYC) ? INHIBIT_CYC : TIMEOUT_CYC;
  localparam int TW          = $clog2(TMR_MAX + 1);
  localparam logic [TW-1:0] INHIBIT_LOAD = TW'(INHIBIT_CYC - 1);
  localparam logic [TW-1:0] TIMEOUT_LOAD = TW'(TIMEOUT_CYC - 1);

  ps2_state_t    state, state_nx;
  logic [8:0]    shreg;
  logic [3:0]    bit_idx;
  logic          d_oe_r;
  logic [TW-1:0] tmr;
  logic          accept, fail, done, tmo, can_retry;
  logic          lev_c, fall_c, lev_d, unused_fall_d;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_c (
    .clock(clock), .reset(reset), .pad(ps2c_in), .level(lev_c), .fall(fall_c)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_d (
    .clock(clock), .reset(reset), .pad(ps2d_in), .level(lev_d), .fall(unused_fall_d)
  );

  assign accept = tx_valid && (state == IDLE);

`ifdef PS2_TX_RETRY_EN
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  logic [RW-1:0] retry_cnt;

  assign can_retry = (retry_cnt < RW'(MAX_RETRY));

  always_ff @(posedge clock or posedge reset) begin
    if (reset)                  retry_cnt <= '0;
    else if (accept)            retry_cnt <= '0;
    else if (fail && can_retry) retry_cnt <= retry_cnt + RW'(1);
  end
`else
  assign can_retry = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // A device clock edge always beats a timer expiring in the same cycle.
  always_comb begin
    state_nx = state;
    fail     = 1'b0;
    done     = 1'b0;
    tmo      = (tmr == '0) && !fall_c;
    case (state)
      IDLE:    if (accept) state_nx = INHIBIT;
      INHIBIT: if (d_oe_r) state_nx = REQ;
      REQ: begin
        if (fall_c)   state_nx = DATA;
        else if (tmo) fail = 1'b1;
      end
      DATA: begin
        if (fall_c) begin
          if (bit_idx == 4'd8) state_nx = STOP_W;
        end else if (tmo) begin
          fail = 1'b1;
        end
      end
      STOP_W: begin
        if (fall_c)   state_nx = ACK;
        else if (tmo) fail = 1'b1;
      end
      ACK: begin
        if (fall_c) begin
          if (lev_d) fail = 1'b1;
          else       state_nx = RELEASE;
        end else if (tmo) begin
          fail = 1'b1;
        end
      end
      RELEASE: begin
        if (lev_c && lev_d) begin
          done     = 1'b1;
          state_nx = IDLE;
        end else if (tmo) begin
          fail = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
    if (fail) state_nx = can_retry ? INHIBIT : IDLE;
  end

  always_comb begin
    ps2c_oe  = (state == INHIBIT);
    ps2d_oe  = d_oe_r;
    busy     = (state != IDLE);
    tx_ready = (state == IDLE);
    tx_done  = done;
    tx_error = fail && !can_retry;
  end

  // shreg holds {parity, data}; bit_idx selects the next bit to drive.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shreg   <= '0;
      bit_idx <= '0;
      d_oe_r  <= 1'b0;
      tmr     <= '0;
    end else if (fail) begin
      d_oe_r <= 1'b0;
      tmr    <= INHIBIT_LOAD;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            shreg <= {odd_parity(tx_data), tx_data};
            tmr   <= INHIBIT_LOAD;
          end
        end
        INHIBIT: begin
          if (d_oe_r)          tmr    <= TIMEOUT_LOAD;
          else if (tmr == '0)  d_oe_r <= 1'b1;
          else                 tmr    <= tmr - TW'(1);
        end
        default: begin
          if (fall_c)          tmr <= TIMEOUT_LOAD;
          else if (tmr != '0)  tmr <= tmr - TW'(1);
          if (fall_c) begin
            case (state)
              REQ: begin
                d_oe_r  <= ~shreg[0];
                bit_idx <= 4'd1;
              end
              DATA: begin
                d_oe_r  <= ~shreg[bit_idx];
                bit_idx <= bit_idx + 4'd1;
              end
              STOP_W:  d_oe_r <= 1'b0;
              default: ;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain device model clocking frames, frame contents
// checked against an arithmetic parity/frame model.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int CLK_HZ = 1000000;
  localparam int INH    = 120;
  localparam int TMO    = 2000;
  localparam int H      = 20;
`ifdef PS2_TX_RETRY_EN
  localparam int RETRIES = 2;
`else
  localparam int RETRIES = 0;
`endif

  logic       clock = 1'b0;
  logic       reset;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready, ps2c_in, ps2d_in, ps2c_oe, ps2d_oe, tx_done, tx_error, busy;
  logic       dev_c_low, dev_d_low;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int d0, e0, hold, cnt, w, seen;
  logic [9:0] bits;
  logic [9:0] expf;
  logic [7:0] b;

  assign ps2c_in = ~(ps2c_oe | dev_c_low);
  assign ps2d_in = ~(ps2d_oe | dev_d_low);

  ps2_host_tx #(
    .CLK_FREQ_HZ(CLK_HZ), .INHIBIT_US(120), .TIMEOUT_US(2000), .FILTER_LEN(8)
  ) dut (
    .clock(clock), .reset(reset), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .ps2c_in(ps2c_in), .ps2d_in(ps2d_in),
    .ps2c_oe(ps2c_oe), .ps2d_oe(ps2d_oe), .tx_done(tx_done),
    .tx_error(tx_error), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clock) begin
    if (tx_done) done_cnt++;
    if (tx_error) err_cnt++;
    if (tx_done || tx_error) chk("done_err_excl", {31'd0, tx_done & tx_error}, 32'd0);
  end

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  // Frame as the device sees it: 8 data bits LSB first, odd parity, stop.
  function automatic logic [9:0] frame_of(input logic [7:0] v);
    int ones;
    ones = $countones(v);
    return {1'b1, (ones % 2 == 0) ? 1'b1 : 1'b0, v};
  endfunction

  task automatic send(input logic [7:0] v);
    int k;
    k = 0;
    while (!tx_ready && k < 5000) begin tick(); k++; end
    chk("ready_wait", {31'd0, tx_ready}, 32'd1);
    tx_data  = v;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    chk("ready_drop", {31'd0, tx_ready}, 32'd0);
  endtask

  task automatic dev_frame(input int nclk, input bit nack, input int poke_at,
                           input logic [7:0] poke_byte,
                           output logic [9:0] fb, output int hld);
    int k;
    fb  = '0;
    hld = 0;
    k   = 0;
    while (!ps2c_oe && k < 1000) begin tick(); k++; end
    chk("inhibit_seen", {31'd0, ps2c_oe}, 32'd1);
    while (ps2c_oe && hld < 5000) begin hld++; tick(); end
    repeat (30) tick();
    for (int n = 1; n <= nclk; n++) begin
      dev_c_low = 1'b1;
      if (n == poke_at) begin
        tx_data  = poke_byte;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        repeat (H - 1) tick();
      end else begin
        repeat (H) tick();
      end
      dev_c_low = 1'b0;
      if (n <= 10) fb[n-1] = ps2d_in;
      if (n == 10) begin
        repeat (4) tick();
        dev_d_low = !nack;
        repeat (H - 4) tick();
      end else begin
        repeat (H) tick();
      end
    end
    dev_d_low = 1'b0;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy && k < 6000) begin tick(); k++; end
    chk("idle_wait", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; tx_valid = 1'b0; tx_data = '0; dev_c_low = 1'b0; dev_d_low = 1'b0;
    repeat (3) tick();
    chk("rst_c_oe", {31'd0, ps2c_oe}, 32'd0);
    chk("rst_d_oe", {31'd0, ps2d_oe}, 32'd0);
    chk("rst_ready", {31'd0, tx_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, tx_done}, 32'd0);
    chk("rst_err", {31'd0, tx_error}, 32'd0);
    reset = 1'b0;
    repeat (20) tick();

    // set-LEDs command, ACKed
    d0 = done_cnt; e0 = err_cnt;
    send(PS2_CMD_SET_LEDS);
    dev_frame(11, 1'b0, 0, 8'h00, bits, hold);
    wait_idle();
    chk("ed_frame", bits, frame_of(8'hED));
    chk("ed_hold", hold, INH + 1);
    chk("ed_done", done_cnt - d0, 1);
    chk("ed_err", err_cnt - e0, 0);

    // back-to-back 0x01 then 0xFF
    d0 = done_cnt;
    send(8'h01);
    dev_frame(11, 1'b0, 0, 8'h00, bits, hold);
    wait_idle();
    chk("b2b_01_frame", bits, frame_of(8'h01));
    chk("b2b_01_par", {31'd0, bits[8]}, 32'd0);
    send(PS2_CMD_RESET);
    dev_frame(11, 1'b0, 0, 8'h00, bits, hold);
    wait_idle();
    chk("b2b_ff_frame", bits, frame_of(8'hFF));
    chk("b2b_ff_par", {31'd0, bits[8]}, 32'd1);
    chk("b2b_done", done_cnt - d0, 2);

    // device never clocks
    d0 = done_cnt; e0 = err_cnt;
    b = 8'($urandom_range(0, 255));
    send(b);
    for (int a = 0; a <= RETRIES; a++) begin
      w = 0;
      while (!ps2c_oe && w < 1000) begin tick(); w++; end
      while (ps2c_oe && w < 5000) begin tick(); w++; end
      cnt = 1;
      while (!(tx_error || ps2c_oe) && cnt < TMO + 100) begin tick(); cnt++; end
      chk("tmo_cycles", cnt, (a == RETRIES) ? TMO : TMO + 1);
    end
    tick();
    chk("tmo_c_oe", {31'd0, ps2c_oe}, 32'd0);
    chk("tmo_d_oe", {31'd0, ps2d_oe}, 32'd0);
    chk("tmo_ready", {31'd0, tx_ready}, 32'd1);
    chk("tmo_err", err_cnt - e0, 1);
    chk("tmo_done", done_cnt - d0, 0);

    // NACK from the device on every attempt
    d0 = done_cnt; e0 = err_cnt;
    b = 8'($urandom_range(0, 255));
    send(b);
    for (int a = 0; a <= RETRIES; a++) begin
      dev_frame(11, 1'b1, 0, 8'h00, bits, hold);
      chk("nack_frame", bits, frame_of(b));
    end
    wait_idle();
    chk("nack_err", err_cnt - e0, 1);
    chk("nack_done", done_cnt - d0, 0);

    // reset while bit 4 is on the wire
    d0 = done_cnt; e0 = err_cnt;
    b = 8'hA5;
    expf = frame_of(b);
    send(b);
    dev_frame(5, 1'b0, 0, 8'h00, bits, hold);
    chk("mid_bits", bits[4:0], expf[4:0]);
    chk("mid_d_oe", {31'd0, ps2d_oe}, {31'd0, ~b[4]});
    reset = 1'b1;
    #1;
    chk("mid_rst_c_oe", {31'd0, ps2c_oe}, 32'd0);
    chk("mid_rst_d_oe", {31'd0, ps2d_oe}, 32'd0);
    repeat (2) tick();
    reset = 1'b0;
    repeat (20) tick();
    chk("mid_ready", {31'd0, tx_ready}, 32'd1);
    chk("mid_no_pulse", (done_cnt - d0) + (err_cnt - e0), 0);
    send(PS2_CMD_ENABLE);
    dev_frame(11, 1'b0, 0, 8'h00, bits, hold);
    wait_idle();
    chk("f4_frame", bits, frame_of(8'hF4));
    chk("f4_done", done_cnt - d0, 1);

    // tx_valid while busy is dropped
    d0 = done_cnt;
    send(8'hC3);
    dev_frame(11, 1'b0, 3, 8'h3C, bits, hold);
    wait_idle();
    chk("poke_frame", bits, frame_of(8'hC3));
    chk("poke_done", done_cnt - d0, 1);
    seen = 0;
    repeat (300) begin
      tick();
      if (ps2c_oe || busy) seen++;
    end
    chk("poke_no_second", seen, 0);

    // random bytes
    repeat (4) begin
      d0 = done_cnt; e0 = err_cnt;
      b = 8'($urandom_range(0, 255));
      send(b);
      dev_frame(11, 1'b0, 0, 8'h00, bits, hold);
      wait_idle();
      chk("rand_frame", bits, frame_of(b));
      chk("rand_done", done_cnt - d0, 1);
      chk("rand_err", err_cnt - e0, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
